// File: rtl/ldl_pkg.sv
// Shared helpers for the ldl round-robin arbiter: index-width derivation
// and modulo-n increment used for pointer wrap.
package ldl_pkg;

   // Ceiling log2, never below 1 so a single requester still gets a 1-bit index.
   function automatic int ldl_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Increment modulo n, so non-power-of-two counts wrap at n-1, not at 2^width-1.
   function automatic int ldl_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational circular first-one finder: lowest set bit of req at or above
// start, wrapping through 0, using a doubled request vector.
module ldl_rr_pick
   import ldl_pkg::*;
#(
   parameter int REQ_NUM   = 8,
   parameter int IDX_WIDTH = ldl_clog2(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0]   req,
   input  logic [IDX_WIDTH-1:0] start,
   output logic                 found,
   output logic [IDX_WIDTH-1:0] idx
);

   localparam int DBL = 2 * REQ_NUM;
   localparam logic [IDX_WIDTH:0] N_W = (IDX_WIDTH + 1)'(REQ_NUM);

   logic [DBL-1:0]     dbl;
   logic [DBL-1:0]     masked;
   logic [IDX_WIDTH:0] pos;

   // The upper copy covers indices below start, so a single masked scan wraps.
   assign dbl    = {req, req};
   assign masked = dbl & ({DBL{1'b1}} << start);
   assign found  = |req;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      pos = '0;
      for (int i = DBL - 1; i >= 0; i--) begin
         if (masked[i]) pos = (IDX_WIDTH + 1)'(i);
      end
   end

   assign idx = IDX_WIDTH'((pos >= N_W) ? pos - N_W : pos);

endmodule

// File: rtl/ldl_rr_arb_bin.sv
// Round-robin arbiter with registered binary grant index and valid/ready
// handshake; grants are held until accepted, then priority rotates past the winner.
module ldl_rr_arb_bin
   import ldl_pkg::*;
#(
   parameter int REQ_NUM   = 8,
   localparam int IDX_WIDTH = ldl_clog2(REQ_NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [REQ_NUM-1:0]   req,
   input  logic                 gnt_rdy,
   output logic                 gnt_vld,
   output logic [IDX_WIDTH-1:0] gnt_idx,
   output logic [IDX_WIDTH-1:0] gnt_ptr
);

   logic                 accept;
   logic                 load;
   logic [IDX_WIDTH-1:0] next_ptr;
   logic [IDX_WIDTH-1:0] start;
   logic                 found;
   logic [IDX_WIDTH-1:0] pick_idx;

   assign accept   = gnt_vld & gnt_rdy;
   assign load     = !gnt_vld | accept;
   assign next_ptr = IDX_WIDTH'(ldl_wrap_inc(int'(gnt_idx), REQ_NUM));
   // On accept the pointer update lands this same edge, so search from its next value.
   assign start    = accept ? next_ptr : gnt_ptr;

   ldl_rr_pick #(
      .REQ_NUM   (REQ_NUM),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req   (req),
      .start (start),
      .found (found),
      .idx   (pick_idx)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
         gnt_ptr <= '0;
      end else begin
         if (accept) gnt_ptr <= next_ptr;
         if (load) begin
            if (en && found) begin
               gnt_vld <= 1'b1;
               gnt_idx <= pick_idx;
            end else begin
               gnt_vld <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/ldl_rr_arb_bin.md
Name: ldl_rr_arb_bin

Overview:
- Round-robin arbiter with a registered binary grant index and a valid/ready output handshake.
- Produces a binary index of the winning requester. It sits directly upstream of the team's binary-to-one-hot decoder: `gnt_vld` drives that decoder's `en`, and `gnt_idx` drives its `x`.
- The decoder's BIN_WIDTH equals IDX_WIDTH.
- Holds each grant stable until the consumer accepts it. It then rotates priority to the requester after the one just served.

Parameters:
- REQ_NUM, 8, number of requesters; legal range 1..256, non-power-of-two allowed.
- IDX_WIDTH, derived localparam = max(1, clog2(REQ_NUM)), width of the binary grant index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; when low, no new grant is loaded.
- req  in  REQ_NUM  request vector, bit i = requester i.
- gnt_rdy  in  1  consumer accepts the current grant.
- gnt_vld  out  1  grant valid (registered).
- gnt_idx  out  IDX_WIDTH  binary index of the granted requester (registered).
- gnt_ptr  out  IDX_WIDTH  current highest-priority index (debug/status, registered).

Behaviour:
- Reset (async assert, sync release): gnt_vld=0, gnt_idx=0, gnt_ptr=0. Reset mid-grant drops any pending grant immediately; no accept is recorded.
- States: EMPTY (gnt_vld=0) and HOLD (gnt_vld=1). The state is implied by gnt_vld; no separate encoding.
- Accept is the cycle in which gnt_vld & gnt_rdy.
- Load slot is the cycle in which !gnt_vld | accept.
- Search start: start = accept ? wrap(gnt_idx+1) : gnt_ptr, where wrap(REQ_NUM-1 + 1) = 0. Wrapping is done mod REQ_NUM, not mod 2^IDX_WIDTH.
- Pick: the first set bit of req scanning circularly from start upward (start, start+1, ..., REQ_NUM-1, 0, ..., start-1).
- In a load slot with en=1 and |req=1: gnt_vld<=1, gnt_idx<=pick.
- In a load slot with en=0 or req all-zero: gnt_vld<=0; gnt_idx keeps its last value.
- HOLD without accept: gnt_idx and gnt_vld stay stable regardless of req or en changes. A grant is never retracted, even if req[gnt_idx] drops.
- gnt_ptr is updated only on accept: gnt_ptr <= wrap(gnt_idx+1). It is otherwise unchanged.
- Latency: req seen in EMPTY at edge N gives gnt_vld=1 after edge N. Back-to-back accepts sustain one grant per cycle.
- gnt_rdy while gnt_vld=0 is ignored.
- A single requester held high is granted every cycle while gnt_rdy=1.
- REQ_NUM=1: gnt_idx is always 0, and the pointer stays 0.
- No combinational path from req or gnt_rdy to any output.

Decomposition:
- Package ldl_pkg:
  - function ldl_clog2 (returns ≥1) used to derive IDX_WIDTH.
  - function ldl_wrap_inc(idx, n) for mod-n increment.
- Sub-module ldl_rr_pick: purely combinational circular first-one finder.
  - Inputs: req[REQ_NUM], start[IDX_WIDTH].
  - Outputs: found, idx[IDX_WIDTH].
  - Implement via a doubled-vector mask plus a priority encoder.
- Top holds only the registers and the load/accept logic.

Test Plan (REQ_NUM=8 unless stated):
- Reset, then req=8'h00, en=1, gnt_rdy=1 for 5 cycles -> gnt_vld=0, gnt_idx=0, gnt_ptr=0 throughout.
- req=8'hFF held, gnt_rdy=1 -> gnt_idx sequence 0,1,2,...,7,0 on consecutive cycles; gnt_ptr trails by one accept.
- req=8'h90 (bits 4,7), gnt_ptr=5 -> grant 7; after accept, ptr=0 and grant 4; after that accept, grant 7 again.
- Grant idx=3 pending, gnt_rdy=0 for 4 cycles while req changes 8'h08→8'h00→8'hF0 -> gnt_idx stays 3 and gnt_vld stays 1. Then gnt_rdy=1 -> next grant 4.
- REQ_NUM=5, req=5'b10001, repeated accepts -> grants 0,4,0,4. Wrap from 4 to 0 with ptr never reaching 5..7.
- Async rst asserted mid-HOLD between clock edges -> gnt_vld=0 immediately. After release with en=0 and req=8'hFF -> no grant. Raise en -> grant 0 on the next edge.
